// File: rtl/ternary_pkg.sv
// Shared trit encoding and encoder state definitions for the ternary datapath blocks.
// Encoding: 00=0, 01=1, 10=2, 11=invalid (never produced by the encoder).
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_0   = 2'b00;
  localparam trit_t TRIT_1   = 2'b01;
  localparam trit_t TRIT_2   = 2'b10;
  localparam trit_t TRIT_INV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } enc_state_t;

endpackage

// File: rtl/ternary_div3_step.sv
// Combinational restoring divide-by-3 over W bits: quo = x/3, rem = x%3 (0..2).
// No multipliers; one compare-subtract per input bit, MSB first.
module ternary_div3_step
  import ternary_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] quo,
  output trit_t        rem
);

  logic [2:0]   w_part;
  logic [1:0]   w_rem;
  logic [W-1:0] w_quo;

  // Partial remainder stays below 3, so {rem, bit} never exceeds 5.
  always_comb begin
    w_part = 3'b000;
    w_rem  = 2'b00;
    w_quo  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      w_part = {w_rem, x[i]};
      if (w_part >= 3'd3) begin
        w_quo[i] = 1'b1;
        w_rem    = 2'(w_part - 3'd3);
      end else begin
        w_quo[i] = 1'b0;
        w_rem    = w_part[1:0];
      end
    end
  end

  assign quo = w_quo;
  assign rem = trit_t'(w_rem);

endmodule

// File: rtl/ternary_bin2trit_encoder.sv
// Sequential binary-to-trit converter: one divide-by-3 step per cycle, LS trit first.
// Optional TERNARY_ENC_EARLY_EXIT_EN stops as soon as the quotient reaches zero.
module ternary_bin2trit_encoder
  import ternary_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int TRITS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIN_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*TRITS-1:0] out_trits,
  output logic               out_ovf
);

  localparam int IDX_W = (TRITS > 1) ? $clog2(TRITS) : 1;

  enc_state_t         r_state;
  logic [BIN_W-1:0]   r_q;
  logic [IDX_W-1:0]   r_idx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*TRITS-1:0] r_trits;
  logic               r_ovf;

  logic [BIN_W-1:0]   w_quo;
  trit_t              w_rem;
  logic               w_last;
  logic               w_exit;

  ternary_div3_step #(.W(BIN_W)) u_div3 (
    .x   (r_q),
    .quo (w_quo),
    .rem (w_rem)
  );

  assign w_last = (r_idx == IDX_W'(TRITS - 1));

`ifdef TERNARY_ENC_EARLY_EXIT_EN
  assign w_exit = w_last || (w_quo == '0);
`else
  assign w_exit = w_last;
`endif

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_trits     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_q        <= in_data;
            r_idx      <= '0;
            r_trits    <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= CONV;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        CONV: begin
          r_trits[{r_idx, 1'b0} +: 2] <= w_rem;
          r_q   <= w_quo;
          r_idx <= r_idx + IDX_W'(1);
          if (w_exit) begin
            // Early exit never sees a nonzero quotient before the last trit.
            r_ovf       <= w_last && (w_quo != '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= CONV;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_trits = r_trits;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_ternary_bin2trit_encoder.sv
// Directed self-checking bench for ternary_bin2trit_encoder (TRITS=6 and an overflow-prone TRITS=4 instance).
module tb_ternary_bin2trit_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [7:0]  in_data;
  logic [11:0] out_trits;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4;
  logic [7:0]  in_data4;
  logic [7:0]  out_trits4;

  int n_checks;
  int n_pass;

  ternary_bin2trit_encoder #(.BIN_W(8), .TRITS(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_trits(out_trits), .out_ovf(out_ovf)
  );

  ternary_bin2trit_encoder #(.BIN_W(8), .TRITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_trits(out_trits4), .out_ovf(out_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model6(input int v);
    logic [11:0] r;
    int q;
    r = '0;
    q = v;
    for (int i = 0; i < 6; i++) begin
      r[2*i +: 2] = 2'(q % 3);
      q = q / 3;
    end
    return r;
  endfunction

  function automatic int exp_lat6(input int v);
`ifdef TERNARY_ENC_EARLY_EXIT_EN
    int n;
    int q;
    n = 0;
    q = v;
    while (q != 0) begin
      n++;
      q = q / 3;
    end
    if (n == 0) n = 1;
    if (n > 6) n = 6;
    return n;
`else
    return 6 + (v & 0);
`endif
  endfunction

  // Offer one word to the 6-trit DUT; lat = clock edges from accept to out_valid.
  task automatic send6(input logic [7:0] v, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send4(input logic [7:0] v, output int lat);
    int n;
    n = 0;
    while (!in_ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid4 = 1'b1;
    in_data4  = v;
    @(negedge clk);
    in_valid4 = 1'b0;
    in_data4  = 8'h00;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take6();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic take4();
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_ovf, out_trits} !== 15'h0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b ovf=%b trits=%h, want all 0", in_ready, out_valid, out_ovf, out_trits);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0 before an edge", in_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1)
      $display("FAIL ready_after_reset: got %b/%b want 1/1", in_ready, in_ready4);
    else n_pass++;
  endtask

  task automatic test_zero();
    int lat;
    send6(8'd0, lat);
    n_checks++;
    if (lat != exp_lat6(0)) $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat6(0));
    else n_pass++;
    n_checks++;
    if (out_trits !== 12'h000 || out_ovf !== 1'b0)
      $display("FAIL zero_value: got trits=%h ovf=%b want 000/0", out_trits, out_ovf);
    else n_pass++;
    take6();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL zero_handshake: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_max();
    int lat;
    send6(8'd255, lat);
    n_checks++;
    if (lat != 6 || out_trits !== 12'h414 || out_ovf !== 1'b0)
      $display("FAIL max_value: got lat=%0d trits=%h ovf=%b want 6/414/0", lat, out_trits, out_ovf);
    else n_pass++;
    take6();
  endtask

  task automatic test_sweep();
    int lat;
    for (int v = 0; v < 256; v++) begin
      send6(8'(v), lat);
      n_checks++;
      if (out_trits !== model6(v) || out_ovf !== 1'b0 || lat != exp_lat6(v))
        $display("FAIL sweep_%0d: got trits=%h ovf=%b lat=%0d want %h/0/%0d",
                 v, out_trits, out_ovf, lat, model6(v), exp_lat6(v));
      else n_pass++;
      take6();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send6(8'd200, lat);
    // Extra input traffic during DONE must be ignored.
    in_valid = 1'b1;
    in_data  = 8'd17;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_trits !== 12'h252 || out_ovf !== 1'b0)
        $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b trits=%h ovf=%b want 1/0/252/0",
                 c, out_valid, in_ready, out_trits, out_ovf);
      else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    take6();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL backpressure_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL backpressure_single: got vld=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int lat;
    send4(8'd81, lat);
    n_checks++;
    if (lat != 4 || out_trits4 !== 8'h00 || out_ovf4 !== 1'b1)
      $display("FAIL overflow_81: got lat=%0d trits=%h ovf=%b want 4/00/1", lat, out_trits4, out_ovf4);
    else n_pass++;
    take4();
    send4(8'd80, lat);
    n_checks++;
    if (lat != 4 || out_trits4 !== 8'hAA || out_ovf4 !== 1'b0)
      $display("FAIL overflow_80: got lat=%0d trits=%h ovf=%b want 4/aa/0", lat, out_trits4, out_ovf4);
    else n_pass++;
    take4();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_trits !== 12'h000)
      $display("FAIL reset_mid_conv: got vld=%b rdy=%b trits=%h want 0/0/000", out_valid, in_ready, out_trits);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send6(8'd5, lat);
    n_checks++;
    if (out_trits !== 12'h006 || out_ovf !== 1'b0 || lat != exp_lat6(5))
      $display("FAIL reset_mid_next: got trits=%h ovf=%b lat=%0d want 006/0/%0d", out_trits, out_ovf, lat, exp_lat6(5));
    else n_pass++;
    take6();
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    send6(8'd5, lat);
    n_checks++;
    if (out_trits !== 12'h006 || lat != exp_lat6(5))
      $display("FAIL b2b_first: got trits=%h lat=%0d want 006/%0d", out_trits, lat, exp_lat6(5));
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_ready_in_done: got %b want 0", in_ready);
    else n_pass++;
    take6();
    gap = 0;
    while (!in_ready && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    n_checks++;
    if (gap != 0) $display("FAIL b2b_ready_gap: got %0d extra cycles want 0", gap);
    else n_pass++;
    send6(8'd255, lat);
    n_checks++;
    if (out_trits !== 12'h414 || out_ovf !== 1'b0 || lat != exp_lat6(255))
      $display("FAIL b2b_second: got trits=%h ovf=%b lat=%0d want 414/0/%0d", out_trits, out_ovf, lat, exp_lat6(255));
    else n_pass++;
    take6();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    in_data4   = 8'h00;
    out_ready4 = 1'b0;
    rst_n      = 1'b1;
    #3;
    test_reset();
    test_zero();
    test_max();
    test_sweep();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
